// File: rtl/masked_kat_pkg.sv
// rtl/masked_kat_pkg.sv - KAT vectors, FSM states and LFSR helpers for the masked AES KAT sequencer
package masked_kat_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST_HOLD,
      FEED,
      WAIT_DONE,
      CHECK,
      FINISH
   } seqState_t;

   localparam logic [31:0] LFSR_POLY = 32'h80200003;

   localparam logic [127:0] KAT_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

   // The four base vectors repeat to fill the 16-entry ROM.
   localparam logic [127:0] KAT_PT [16] = '{
      128'h340737e0a29831318d305a88a8f64332, 128'h0,
      128'h0123456789abcdef0123456789abcdef, 128'h00112233445566778899aabbccddeeff,
      128'h340737e0a29831318d305a88a8f64332, 128'h0,
      128'h0123456789abcdef0123456789abcdef, 128'h00112233445566778899aabbccddeeff,
      128'h340737e0a29831318d305a88a8f64332, 128'h0,
      128'h0123456789abcdef0123456789abcdef, 128'h00112233445566778899aabbccddeeff,
      128'h340737e0a29831318d305a88a8f64332, 128'h0,
      128'h0123456789abcdef0123456789abcdef, 128'h00112233445566778899aabbccddeeff
   };

   localparam logic [127:0] KAT_CT [16] = '{
      128'h320b6a19978511dcfb09dc021d842539, 128'h6f541bb947f0423eb399b81a0c6bf77d,
      128'h67f231d4d67ef497245075cfa63b5ae0, 128'hc1b8350e659b5d432f1bb87a1c67492f,
      128'h320b6a19978511dcfb09dc021d842539, 128'h6f541bb947f0423eb399b81a0c6bf77d,
      128'h67f231d4d67ef497245075cfa63b5ae0, 128'hc1b8350e659b5d432f1bb87a1c67492f,
      128'h320b6a19978511dcfb09dc021d842539, 128'h6f541bb947f0423eb399b81a0c6bf77d,
      128'h67f231d4d67ef497245075cfa63b5ae0, 128'hc1b8350e659b5d432f1bb87a1c67492f,
      128'h320b6a19978511dcfb09dc021d842539, 128'h6f541bb947f0423eb399b81a0c6bf77d,
      128'h67f231d4d67ef497245075cfa63b5ae0, 128'hc1b8350e659b5d432f1bb87a1c67492f
   };

   // Right-shifting Galois step; the mask lands on the MSB side.
   function automatic logic [31:0] lfsrStep(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/masked_kat_sequencer_if.sv
// rtl/masked_kat_sequencer_if.sv - Signal bundle between the KAT sequencer and the masked Cipher core
interface masked_kat_sequencer_if #(
   parameter int NUM_SHARES = 2,
   parameter int RAND_W     = 160
);
   logic                      dut_rst;
   logic [128*NUM_SHARES-1:0] dut_in;
   logic [128*NUM_SHARES-1:0] dut_key;
   logic [RAND_W-1:0]         dut_r;
   logic [128*NUM_SHARES-1:0] dut_out;
   logic                      dut_done;

   modport master (
      output dut_rst, dut_in, dut_key, dut_r,
      input  dut_out, dut_done
   );

   modport slave (
      input  dut_rst, dut_in, dut_key, dut_r,
      output dut_out, dut_done
   );
endinterface

// File: rtl/masked_kat_sequencer_mask_lfsr.sv
// rtl/masked_kat_sequencer_mask_lfsr.sv - 32-bit Galois LFSR unrolled to an arbitrary-width mask word
module mask_lfsr
   import masked_kat_pkg::*;
#(
   parameter int OUT_W = 288
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [31:0]      seed,
   output logic [OUT_W-1:0] rnd
);
   localparam int WORDS = (OUT_W + 31) / 32;

   logic [31:0]         lfsrState;
   logic [31:0]         nextState;
   logic [WORDS*32-1:0] taps;

   // Word j is the state after j steps; the register jumps WORDS steps per cycle.
   always_comb begin
      logic [31:0] s;
      s    = lfsrState;
      taps = '0;
      for (int j = 0; j < WORDS; j++) begin
         taps[j*32 +: 32] = s;
         s = lfsrStep(s);
      end
      nextState = s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsrState <= 32'h1;
      end else if (load) begin
         lfsrState <= (seed == 32'h0) ? 32'h1 : seed;
      end else if (en) begin
         lfsrState <= nextState;
      end
   end

   assign rnd = taps[OUT_W-1:0];

endmodule

// File: rtl/masked_kat_sequencer.sv
// rtl/masked_kat_sequencer.sv - Streams masked KAT vectors into the Cipher core and checks the recombined results
module masked_kat_sequencer
   import masked_kat_pkg::*;
#(
   parameter int NUM_SHARES = 2,
   parameter int N_VEC      = 5,
   parameter int RAND_W     = 160,
   parameter int RST_CYCLES = 20,
   parameter int TIMEOUT    = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     mask_en,
   input  logic [31:0]              seed,
   masked_kat_sequencer_if.master   core,
   output logic                     busy,
   output logic                     pass,
   output logic                     fail,
   output logic                     timeout,
   output logic [4:0]               err_cnt,
   output logic [3:0]               first_err_idx
);
   localparam int SW = 128 * NUM_SHARES;
   localparam int MW = 128 * (NUM_SHARES - 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int HW = $clog2(RST_CYCLES + 1);

   seqState_t          state;
   logic [HW-1:0]      holdCnt;
   logic [TW-1:0]      waitCnt;
   logic [3:0]         vecIdx;
   logic [3:0]         chkIdx;
   logic               doneQ;
   logic [MW+RAND_W-1:0] rnd;
   logic [MW-1:0]      masks;
   logic [RAND_W-1:0]  rFresh;
   logic               startOk;
   logic               doneRise;
   logic               checking;
   logic               vecBad;

   function automatic logic [SW-1:0] share(input logic [127:0] v, input logic [MW-1:0] m);
      logic [127:0] acc;
      acc = v;
      for (int i = 0; i < NUM_SHARES - 1; i++) acc ^= m[i*128 +: 128];
      return {m, acc};
   endfunction

   function automatic logic [127:0] recombine(input logic [SW-1:0] s);
      logic [127:0] acc;
      acc = '0;
      for (int i = 0; i < NUM_SHARES; i++) acc ^= s[i*128 +: 128];
      return acc;
   endfunction

   assign startOk  = start && (state == IDLE);
   assign masks    = mask_en ? rnd[MW-1:0] : '0;
   assign rFresh   = mask_en ? rnd[MW+RAND_W-1:MW] : '0;
   assign doneRise = core.dut_done && !doneQ;
   assign checking = (state == CHECK) || (state == WAIT_DONE && doneRise);
   // A dropped done during CHECK means the core lost a vector: score it as a miss.
   assign vecBad   = !core.dut_done || (recombine(core.dut_out) != KAT_CT[chkIdx]);

   mask_lfsr #(.OUT_W(MW + RAND_W)) uLfsr (
      .clk  (clk),
      .rst  (rst),
      .load (startOk),
      .en   (busy),
      .seed (seed),
      .rnd  (rnd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         timeout       <= 1'b0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         core.dut_rst  <= 1'b1;
         core.dut_in   <= '0;
         core.dut_key  <= '0;
         core.dut_r    <= '0;
         holdCnt       <= '0;
         waitCnt       <= '0;
         vecIdx        <= '0;
         chkIdx        <= '0;
         doneQ         <= 1'b0;
      end else begin
         doneQ      <= core.dut_done;
         core.dut_r <= rFresh;
         case (state)
            IDLE: begin
               if (start) begin
                  pass          <= 1'b0;
                  fail          <= 1'b0;
                  timeout       <= 1'b0;
                  err_cnt       <= '0;
                  first_err_idx <= '0;
                  busy          <= 1'b1;
                  core.dut_rst  <= 1'b1;
                  core.dut_in   <= share(KAT_PT[0], masks);
                  core.dut_key  <= share(KAT_KEY, masks);
                  holdCnt       <= '0;
                  state         <= RST_HOLD;
               end
            end
            RST_HOLD: begin
               core.dut_in <= share(KAT_PT[0], masks);
               if (holdCnt == HW'(RST_CYCLES - 1)) begin
                  vecIdx <= '0;
                  state  <= FEED;
               end else begin
                  holdCnt <= holdCnt + 1'b1;
               end
            end
            FEED: begin
               // dut_in is loaded one cycle ahead so FEED cycle k shows vector k.
               if (vecIdx == 4'(N_VEC - 1)) begin
                  core.dut_rst <= 1'b0;
                  waitCnt      <= '0;
                  chkIdx       <= '0;
                  state        <= WAIT_DONE;
               end else begin
                  vecIdx      <= vecIdx + 4'd1;
                  core.dut_in <= share(KAT_PT[vecIdx + 4'd1], masks);
               end
            end
            WAIT_DONE: begin
               if (doneRise) begin
                  if (N_VEC == 1) begin
                     core.dut_rst <= 1'b1;
                     state        <= FINISH;
                  end else begin
                     chkIdx <= 4'd1;
                     state  <= CHECK;
                  end
               end else if (waitCnt == TW'(TIMEOUT - 1)) begin
                  timeout      <= 1'b1;
                  core.dut_rst <= 1'b1;
                  state        <= FINISH;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            CHECK: begin
               if (chkIdx == 4'(N_VEC - 1)) begin
                  core.dut_rst <= 1'b1;
                  state        <= FINISH;
               end else begin
                  chkIdx <= chkIdx + 4'd1;
               end
            end
            FINISH: begin
               pass  <= (err_cnt == 5'd0) && !timeout;
               fail  <= !((err_cnt == 5'd0) && !timeout);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (checking && vecBad) begin
            if (err_cnt == 5'd0) first_err_idx <= chkIdx;
            if (err_cnt != 5'd31) err_cnt <= err_cnt + 5'd1;
         end
      end
   end

endmodule

// File: doc/masked_kat_sequencer.md
Name: masked_kat_sequencer

Overview:
- Synthesizable, parametrised known-answer-test (KAT) sequencer for the fully-pipelined masked AES encryption core (Cipher).
- Generalises the hand-written two-share stimulus flow to NUM_SHARES shares, a configurable vector count, and on-chip fresh-mask generation.
- Automatic recombination, comparison, timeout and error reporting, so the pipeline can be self-tested in silicon or in simulation with no bench logic.
- Sits between a host/debug interface and one Cipher instance.

Parameters:
- NUM_SHARES, 2, number of Boolean shares per 128-bit value (≥2).
- N_VEC, 5, number of KAT vectors streamed per run (≤ 16; ROM in package).
- RAND_W, 160, width of the fresh-randomness bus r to the core.
- RST_CYCLES, 20, cycles the core reset is held before streaming begins.
- TIMEOUT, 1023, maximum cycles to wait for core done after reset release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; launches a run when idle
- mask_en  in  1  1: random shares/r from LFSR; 0: share 1..N-1 and r forced to zero
- seed  in  32  LFSR seed, sampled on accepted start
- dut_rst  out  1  reset to core
- dut_in  out  128*NUM_SHARES  plaintext shares, share 0 in LSBs
- dut_key  out  128*NUM_SHARES  key shares
- dut_r  out  RAND_W  fresh randomness
- dut_out  in  128*NUM_SHARES  ciphertext shares from core
- dut_done  in  1  core output-valid indicator
- busy  out  1  run in progress
- pass  out  1  run finished, all vectors matched
- fail  out  1  run finished with mismatch or timeout
- timeout  out  1  fail caused by missing done
- err_cnt  out  5  number of mismatching vectors
- first_err_idx  out  4  index of first mismatch (valid when err_cnt≠0)

Behaviour:
- Reset: all outputs 0 except dut_rst=1; FSM → IDLE; LFSR=32'h1.
- FSM IDLE → RST_HOLD → FEED → WAIT_DONE → CHECK → FINISH → IDLE.
- IDLE: start=1 → clear pass/fail/timeout/err_cnt/first_err_idx, load seed (seed=0 → 32'h1), busy=1, → RST_HOLD. start in any other state ignored.
- RST_HOLD: dut_rst=1 for RST_CYCLES cycles; dut_in = vector 0 shares.
- FEED: dut_rst=1; one vector per cycle, index 0..N_VEC-1, then → WAIT_DONE.
- Share generation per cycle: shares 1..N-1 = LFSR words (0 if mask_en=0); share 0 = PT ^ XOR(other shares). Key shares formed once at start the same way from KAT_KEY.
- dut_r refreshed every cycle from LFSR when mask_en=1, else 0.
- WAIT_DONE: dut_rst=0, dut_in holds last vector. Rising edge of dut_done → CHECK in the same cycle. TIMEOUT cycles without it → fail=1, timeout=1, → FINISH.
- CHECK: for k=0..N_VEC-1 on consecutive cycles starting at the done edge, recombine XOR of all dut_out shares and compare to KAT_CT[k]. On mismatch: err_cnt++ (saturating at 31); first_err_idx=k on first mismatch. dut_done dropping mid-CHECK counts each remaining vector as a mismatch.
- FINISH, one cycle: pass = (err_cnt==0 && !timeout), fail otherwise; busy=0; dut_rst=1; → IDLE. Status holds until the next accepted start or rst.
- rst mid-run: immediate return to IDLE, status cleared, dut_rst=1.
- LFSR: 32-bit Galois, poly 32'h80200003, advances every cycle while busy; wide words built by concatenating successive 32-bit taps of an unrolled step.

Decomposition:
- Package masked_kat_pkg:
  - KAT_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b
  - KAT_PT/KAT_CT arrays (16 entries):
    - 340737e0a29831318d305a88a8f64332 → 320b6a19978511dcfb09dc021d842539
    - 0 → 6f541bb947f0423eb399b81a0c6bf77d
    - 0123456789abcdef0123456789abcdef → 67f231d4d67ef497245075cfa63b5ae0
    - 00112233445566778899aabbccddeeff → c1b8350e659b5d432f1bb87a1c67492f
    - 340737e0…32 → 320b…39
  - FSM state enum; LFSR polynomial constant.
- Sub-module mask_lfsr: parametrised output width, seed load, enable.

Test Plan:
- Golden Cipher model (correct), mask_en=0, start → after done, pass=1, fail=0, err_cnt=0.
- Same with mask_en=1, seed=32'hdeadbeef, NUM_SHARES=3 → dut_in shares nonzero, pass=1.
- Model corrupts vector 2 output bit 0 → fail=1, err_cnt=1, first_err_idx=2.
- Model never asserts done → fail=1, timeout=1 exactly TIMEOUT cycles after dut_rst falls.
- rst asserted in FEED, then new start → run completes, pass=1, no stale status.
- start pulsed while busy → ignored; exactly one FINISH, err_cnt unchanged.
